gray_conv_pipe: RTL and testbench

Parametrised, pipelined Gray/binary code converter with a valid/ready handshake on both sides. Each beat selects its own direction: Gray-to-binary or binary-to-Gray. In Gray-to-binary mode the block also checks that successive input codes are unit-distance, flags violations per beat and keeps a saturating error count. It sits between the ALU datapath and counter/position-encoder sources, and replaces fixed-width combinational converters.

---
 rtl/gray_conv_pipe.sv | 116 +++++++++++
 tb/tb_gray_conv_pipe.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/gray_conv_pipe.sv
// rtl/gray_conv_pipe.sv - two-stage Gray/binary converter with unit-distance checking
module gray_conv_pipe #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_mode,
  output logic [WIDTH-1:0] out_data,
  output logic             out_err,
  output logic [CNT_W-1:0] err_count
);

  localparam logic [WIDTH-1:0] DATA_ONE = WIDTH'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b = '0;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  logic             s1_valid;
  logic             s1_mode;
  logic [WIDTH-1:0] s1_data;
  logic             s1_err;
  logic [WIDTH-1:0] prev_code;
  logic             prev_valid;

  logic             s2_load;
  logic             accept;
  logic [WIDTH-1:0] diff;
  logic             not_unit;
  logic             beat_err;

  assign s2_load  = s1_valid && (!out_valid || out_ready);
  assign in_ready = !s1_valid || s2_load;
  assign accept   = in_valid && in_ready;

  // Unit distance means exactly one bit set: nonzero and a power of two.
  assign diff     = in_data ^ prev_code;
  assign not_unit = (diff == '0) || ((diff & (diff - DATA_ONE)) != '0);
  assign beat_err = accept && !in_mode && prev_valid && not_unit && !clear;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_mode  <= 1'b0;
      s1_data  <= '0;
      s1_err   <= 1'b0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_mode  <= in_mode;
      s1_data  <= in_data;
      s1_err   <= beat_err;
    end else if (s2_load) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_mode  <= 1'b0;
      out_data  <= '0;
      out_err   <= 1'b0;
    end else if (s2_load) begin
      out_valid <= 1'b1;
      out_mode  <= s1_mode;
      out_data  <= s1_mode ? bin2gray(s1_data) : gray2bin(s1_data);
      out_err   <= s1_err;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // A Gray beat coinciding with clear still seeds the new sequence.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_code  <= '0;
      prev_valid <= 1'b0;
    end else if (accept && !in_mode) begin
      prev_code  <= in_data;
      prev_valid <= 1'b1;
    end else if (accept || clear) begin
      prev_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (clear) begin
      err_count <= '0;
    end else if (beat_err && (err_count != CNT_MAX)) begin
      err_count <= err_count + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_gray_conv_pipe.sv
// tb/tb_gray_conv_pipe.sv - scoreboard bench for gray_conv_pipe
module tb_gray_conv_pipe;

  localparam int W  = 4;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_mode = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic          out_ready = 1'b1;
  logic          in_ready;
  logic          out_valid;
  logic          out_mode;
  logic [W-1:0]  out_data;
  logic          out_err;
  logic [CW-1:0] err_count;

  gray_conv_pipe #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_mode(out_mode),
    .out_data(out_data), .out_err(out_err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         mode;
    logic [W-1:0] data;
    logic         err;
  } beat_t;

  beat_t q[$];
  int    checks = 0;
  int    errors = 0;
  logic  drop_seen = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: sampled mid-low-phase, after drivers have settled.
  beat_t held;
  logic  held_v = 1'b0;
  always begin
    beat_t e;
    @(negedge clk);
    #2;
    if (!rst_n) begin
      held_v = 1'b0;
    end else begin
      if (held_v && out_valid) begin
        chk("stall_data", 32'(out_data), 32'(held.data));
        chk("stall_mode", 32'(out_mode), 32'(held.mode));
        chk("stall_err",  32'(out_err),  32'(held.err));
      end
      held_v = 1'b0;
      if (in_valid && !in_ready && !drop_seen) begin
        drop_seen = 1'b1;
        chk("held_on_drop", q.size(), 2);
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_beat", 32'(out_data), 32'hFFFF_FFFF);
        end else begin
          e = q.pop_front();
          chk("out_data", 32'(out_data), 32'(e.data));
          chk("out_mode", 32'(out_mode), 32'(e.mode));
          chk("out_err",  32'(out_err),  32'(e.err));
        end
      end else if (out_valid) begin
        held_v    = 1'b1;
        held.mode = out_mode;
        held.data = out_data;
        held.err  = out_err;
      end
    end
  end

  // Called just after a negedge; returns at the negedge after the acceptance edge.
  task automatic send(input logic m, input logic [W-1:0] d, input logic [W-1:0] ed, input logic ee);
    int    n;
    beat_t b;
    n = 0;
    in_valid = 1'b1;
    in_mode  = m;
    in_data  = d;
    #1;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 32'(in_ready), 1);
      in_valid = 1'b0;
    end else begin
      b.mode = m;
      b.data = ed;
      b.err  = ee;
      q.push_back(b);
      @(negedge clk);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", q.size(), 0);
  endtask

  logic [W-1:0] bp_exp [8] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4};

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data",  32'(out_data),  0);
    chk("rst_out_mode",  32'(out_mode),  0);
    chk("rst_out_err",   32'(out_err),   0);
    chk("rst_err_count", 32'(err_count), 0);
    chk("rst_in_ready",  32'(in_ready),  1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Gray-to-binary first beat, with latency check
    send(1'b0, 4'b1101, 4'b1001, 1'b0);
    in_valid = 1'b0;
    chk("lat_not_yet", 32'(out_valid), 0);
    @(negedge clk);
    chk("lat_arrived", 32'(out_valid), 1);
    drain();

    // Binary-to-Gray
    send(1'b1, 4'b1011, 4'b1110, 1'b0);
    in_valid = 1'b0;
    drain();

    // Gray sequence, violation, then clear on a coinciding beat
    send(1'b0, 4'b0000, 4'b0000, 1'b0);
    send(1'b0, 4'b0001, 4'b0001, 1'b0);
    send(1'b0, 4'b0011, 4'b0010, 1'b0);
    send(1'b0, 4'b0010, 4'b0011, 1'b0);
    send(1'b0, 4'b0111, 4'b0101, 1'b1);
    in_valid = 1'b0;
    chk("seq_err_count", 32'(err_count), 1);
    clear = 1'b1;
    send(1'b0, 4'b0111, 4'b0101, 1'b0);
    clear = 1'b0;
    in_valid = 1'b0;
    chk("clear_err_count", 32'(err_count), 0);
    drain();

    // Backpressure: 8 continuous beats, 5-cycle stall mid-stream
    fork
      begin
        for (int i = 0; i < 8; i++) send(1'b1, W'(i), bp_exp[i], 1'b0);
        in_valid = 1'b0;
      end
      begin
        repeat (3) @(negedge clk);
        out_ready = 1'b0;
        repeat (5) @(negedge clk);
        out_ready = 1'b1;
      end
    join
    drain();
    chk("in_ready_dropped", 32'(drop_seen), 1);

    // Saturation
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    for (int i = 0; i < 300; i++) send(1'b0, 4'b0101, 4'b0110, (i != 0));
    in_valid = 1'b0;
    drain();
    chk("sat_err_count", 32'(err_count), 255);

    // Reset with both stages full
    out_ready = 1'b0;
    send(1'b0, 4'b0101, 4'b0110, 1'b1);
    send(1'b0, 4'b0101, 4'b0110, 1'b1);
    in_valid = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_err_count", 32'(err_count), 0);
    chk("midrst_in_ready",  32'(in_ready),  1);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    send(1'b0, 4'b0011, 4'b0010, 1'b0);
    in_valid = 1'b0;
    drain();
    chk("post_rst_err_count", 32'(err_count), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
